// File: rtl/uart_cmd_comm_if.sv
// Pin/handshake bundle between the host UART endpoint (slave) and its
// surroundings (master): serial pins plus the core's cmd/response handshake.
interface uart_cmd_comm_if;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;

  modport slave (
    input  RX, clr_cmd_rdy, resp_data, send_resp,
    output TX, cmd, cmd_rdy, resp_sent, tx_busy
  );

  modport master (
    output RX, clr_cmd_rdy, resp_data, send_resp,
    input  TX, cmd, cmd_rdy, resp_sent, tx_busy
  );
endinterface

// File: rtl/uart_cmd_comm.sv
// Host-side 8N1 UART endpoint: assembles 3 RX bytes into a 24-bit command and
// serialises single response bytes. `define CMD_TIMEOUT_EN to discard stale partial commands.
module uart_cmd_comm #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_comm_if.slave   bus_if
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS == 0) begin : g_bad_params
    $error("uart_cmd_comm: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  // RX path state
  logic             rx_meta_q, rx_sync_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       shadow_hi_q, shadow_hi_d;
  logic [7:0]       shadow_mid_q, shadow_mid_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             rx_byte_ok;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
`endif

  // TX path state
  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic             resp_sent_q, resp_sent_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_idx_q   <= '0;
      shadow_hi_q  <= '0;
      shadow_mid_q <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_data_q    <= '0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      resp_sent_q  <= 1'b0;
    end else begin
      rx_meta_q    <= bus_if.RX;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_idx_q   <= byte_idx_d;
      shadow_hi_q  <= shadow_hi_d;
      shadow_mid_q <= shadow_mid_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
`ifdef CMD_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_data_q    <= tx_data_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      resp_sent_q  <= resp_sent_d;
    end
  end

  // RX framing, byte assembly and command handshake
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_idx_d   = byte_idx_q;
    shadow_hi_d  = shadow_hi_q;
    shadow_mid_d = shadow_mid_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    rx_byte_ok   = 1'b0;
`ifdef CMD_TIMEOUT_EN
    idle_cnt_d   = '0;
`endif

    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_byte_ok = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    // Stale partial command: only counts while waiting between bytes
    if (rx_state_q == S_IDLE && byte_idx_q != 2'd0) begin
      if (idle_cnt_q == TO_LAST) byte_idx_d = 2'd0;
      else                       idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
`endif

    // Clear first so a same-cycle third byte still lands and re-arms cmd_rdy
    if (bus_if.clr_cmd_rdy) cmd_rdy_d = 1'b0;

    if (rx_byte_ok && !cmd_rdy_d) begin
      case (byte_idx_q)
        2'd0: begin
          shadow_hi_d = rx_shift_q;
          byte_idx_d  = 2'd1;
        end
        2'd1: begin
          shadow_mid_d = rx_shift_q;
          byte_idx_d   = 2'd2;
        end
        default: begin
          cmd_d      = {shadow_hi_q, shadow_mid_q, rx_shift_q};
          cmd_rdy_d  = 1'b1;
          byte_idx_d = 2'd0;
        end
      endcase
    end
  end

  // TX serialiser; tx_data_q shifts right so bit 1 is always the next data bit
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_data_d   = tx_data_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = resp_sent_q;

    case (tx_state_q)
      S_IDLE: begin
        if (bus_if.send_resp) begin
          tx_data_d   = bus_if.resp_data;
          resp_sent_d = 1'b0;
          tx_busy_d   = 1'b1;
          tx_d        = 1'b0;
          tx_cnt_d    = '0;
          tx_state_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_data_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_data_d = {1'b1, tx_data_q[7:1]};
            tx_d      = tx_data_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_busy_d   = 1'b0;
          resp_sent_d = 1'b1;
          tx_state_d  = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  assign bus_if.TX        = tx_q;
  assign bus_if.cmd       = cmd_q;
  assign bus_if.cmd_rdy   = cmd_rdy_q;
  assign bus_if.resp_sent = resp_sent_q;
  assign bus_if.tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_uart_cmd_comm.sv
// Bench for uart_cmd_comm: vector table, hand sequences and randomized
// full-duplex traffic checked against a byte-level command model.
module tb_uart_cmd_comm;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_comm_if bus();

  uart_cmd_comm #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Byte-level command model
  int          m_idx;
  logic [7:0]  m_sh [3];
  logic [23:0] m_cmd;
  logic        m_rdy;

  typedef struct {
    logic        clr_first;
    logic        bad_first;
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp_cmd;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_sh[0] = '0; m_sh[1] = '0; m_sh[2] = '0;
    m_cmd = '0;
    m_rdy = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic ok, input int gap_bits);
    if (ok && !m_rdy) begin
      m_sh[m_idx] = b;
      if (m_idx == 2) begin
        m_cmd = {m_sh[0], m_sh[1], m_sh[2]};
        m_rdy = 1'b1;
        m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
`ifdef CMD_TIMEOUT_EN
    if (CPB / 2 + gap_bits * CPB >= TOB * CPB) m_idx = 0;
`else
    if (gap_bits < 0) m_idx = 0;
`endif
  endtask

  function automatic logic tx_expected(input logic [7:0] d, input int c);
    if (c < CPB) return 1'b0;
    if (c < 9 * CPB) return d[3'((c - CPB) / CPB)];
    return 1'b1;
  endfunction

  // Drive one 8N1 frame on RX, then idle for gap_bits bit periods
  task automatic rx_byte(input logic [7:0] d, input logic stop_ok, input int gap_bits);
    logic [9:0] fr;
    fr = {stop_ok, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RX = fr[i];
      repeat (CPB) @(negedge clk);
    end
    bus.RX = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
    model_byte(d, stop_ok, gap_bits);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic check_cmd(input string tag);
    check({tag, " cmd"}, 32'(bus.cmd), 32'(m_cmd));
    check({tag, " cmd_rdy"}, 32'(bus.cmd_rdy), 32'(m_rdy));
  endtask

  // Send d, compare the TX waveform per cycle; optionally poke a second send_resp at ignore_at
  task automatic tx_send_check(input logic [7:0] d, input int ignore_at, input logic [7:0] ignore_d);
    @(negedge clk);
    bus.resp_data = d;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    bus.resp_data = ~d;
    for (int c = 0; c < 11 * CPB - 6; c++) begin
      check($sformatf("tx_line c=%0d", c), 32'(bus.TX), 32'(tx_expected(d, c)));
      if (c == 0 || c == 10 * CPB - 1) begin
        check($sformatf("resp_sent c=%0d", c), 32'(bus.resp_sent), 32'(0));
        check($sformatf("tx_busy c=%0d", c), 32'(bus.tx_busy), 32'(1));
      end
      if (c >= 10 * CPB) begin
        check($sformatf("resp_sent c=%0d", c), 32'(bus.resp_sent), 32'(1));
        check($sformatf("tx_busy c=%0d", c), 32'(bus.tx_busy), 32'(0));
      end
      bus.send_resp = (c == ignore_at);
      if (c == ignore_at) bus.resp_data = ignore_d;
      @(negedge clk);
    end
    bus.send_resp = 1'b0;
  endtask

  initial begin
    logic [23:0] prev_cmd;
    logic [23:0] exp6;

    vecs[0] = '{clr_first: 1'b0, bad_first: 1'b0, b0: 8'h12, b1: 8'h34, b2: 8'h56,
                exp_cmd: 24'h123456, exp_rdy: 1'b1};
    vecs[1] = '{clr_first: 1'b0, bad_first: 1'b0, b0: 8'hAA, b1: 8'hBB, b2: 8'hCC,
                exp_cmd: 24'h123456, exp_rdy: 1'b1};
    vecs[2] = '{clr_first: 1'b1, bad_first: 1'b0, b0: 8'h01, b1: 8'h02, b2: 8'h03,
                exp_cmd: 24'h010203, exp_rdy: 1'b1};
    vecs[3] = '{clr_first: 1'b1, bad_first: 1'b1, b0: 8'h11, b1: 8'h22, b2: 8'h33,
                exp_cmd: 24'h112233, exp_rdy: 1'b1};

    rst = 1'b1;
    bus.RX = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp_data = 8'h00;
    bus.send_resp = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset TX", 32'(bus.TX), 32'(1));
    check("reset cmd", 32'(bus.cmd), 32'(0));
    check("reset cmd_rdy", 32'(bus.cmd_rdy), 32'(0));
    check("reset resp_sent", 32'(bus.resp_sent), 32'(0));
    check("reset tx_busy", 32'(bus.tx_busy), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Vector table: command assembly, drop while ready, clear, framing error
    prev_cmd = 24'h0;
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].clr_first) begin
        do_clr();
        check($sformatf("vec%0d clr cmd_rdy", v), 32'(bus.cmd_rdy), 32'(0));
        check($sformatf("vec%0d clr cmd held", v), 32'(bus.cmd), 32'(prev_cmd));
      end
      if (vecs[v].bad_first) begin
        rx_byte(8'h5A, 1'b0, 2);
        check($sformatf("vec%0d bad byte cmd_rdy", v), 32'(bus.cmd_rdy), 32'(0));
      end
      rx_byte(vecs[v].b0, 1'b1, 1);
      rx_byte(vecs[v].b1, 1'b1, 1);
      rx_byte(vecs[v].b2, 1'b1, 1);
      check($sformatf("vec%0d cmd", v), 32'(bus.cmd), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d cmd_rdy", v), 32'(bus.cmd_rdy), 32'(vecs[v].exp_rdy));
      prev_cmd = vecs[v].exp_cmd;
    end

    // Inter-byte gap longer than the timeout window
    do_clr();
    rx_byte(8'h77, 1'b1, 5);
    rx_byte(8'h12, 1'b1, 1);
    rx_byte(8'h34, 1'b1, 1);
    rx_byte(8'h56, 1'b1, 1);
`ifdef CMD_TIMEOUT_EN
    exp6 = 24'h123456;
`else
    exp6 = 24'h771234;
`endif
    check("timeout cmd", 32'(bus.cmd), 32'(exp6));
    check_cmd("timeout model");

    // Short low glitch on RX must not start a byte
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.RX = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (8) @(negedge clk);
      check($sformatf("glitch TX k=%0d", k), 32'(bus.TX), 32'(1));
      check($sformatf("glitch tx_busy k=%0d", k), 32'(bus.tx_busy), 32'(0));
    end
    check_cmd("glitch");

    // Response transmission with ignored re-requests mid-frame and at the stop-bit end
    tx_send_check(8'hA5, 50, 8'hFF);
    tx_send_check(8'h3C, 10 * CPB - 1, 8'hFF);

    // Randomized full-duplex traffic
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_clr();
        check_cmd($sformatf("rand%0d clr", it));
      end
      fork
        begin
          for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            logic ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            rx_byte(b, ok, 1);
            check_cmd($sformatf("rand%0d byte%0d", it, k));
          end
        end
        begin
          if (it % 2 == 0) tx_send_check(8'($urandom), (it == 2) ? 10 * CPB - 1 : -1, 8'hFF);
        end
      join
    end

    // Asynchronous reset in the middle of a transmitted frame
    @(negedge clk);
    bus.resp_data = 8'h00;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (40) @(negedge clk);
    check("pre-reset TX low", 32'(bus.TX), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("async reset TX", 32'(bus.TX), 32'(1));
    check("async reset tx_busy", 32'(bus.tx_busy), 32'(0));
    check("async reset cmd", 32'(bus.cmd), 32'(0));
    check("async reset cmd_rdy", 32'(bus.cmd_rdy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3 * CPB) @(negedge clk);
    check("post-reset TX idle", 32'(bus.TX), 32'(1));
    check("post-reset resp_sent", 32'(bus.resp_sent), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
